// File: rtl/jk_pkg.sv
// jk_pkg: JK operation encodings and next-state helper shared by the JK flops.
package jk_pkg;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return ({j, k} == JK_HOLD) ? q :
           ({j, k} == JK_CLR)  ? 1'b0 :
           ({j, k} == JK_SET)  ? 1'b1 :
           ({j, k} == JK_TGL)  ? ~q : q;
  endfunction
endpackage

// File: rtl/jk_ff_bit.sv
// jk_ff_bit: single-bit JK register with synchronous active-high clear.
module jk_ff_bit
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk)
    q <= reset ? 1'b0 : jk_next(q, j, k);
endmodule

// File: rtl/jk_async_sync.sv
// jk_async_sync: WIDTH-bit dual JK register; Q_asyn is masked by reset combinationally, Q_syn clears only at an edge.
module jk_async_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q_asyn,
  output logic [WIDTH-1:0] Q_syn
);
  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_s;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_bit u_a (.clk(clk), .reset(reset), .j(J[i]), .k(K[i]), .q(q_a[i]));
    jk_ff_bit u_s (.clk(clk), .reset(reset), .j(J[i]), .k(K[i]), .q(q_s[i]));
  end
  // Masking gives immediate clear visibility without an asynchronous flop.
  assign Q_asyn = q_a & ~{WIDTH{reset}};
  assign Q_syn  = q_s;
endmodule

// File: tb/tb_jk_async_sync.sv
// tb_jk_async_sync: directed-vector check of both JK copies, reset masking and per-bit independence.
module tb_jk_async_sync;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] J, K, Q_asyn, Q_syn;
  int n_chk = 0;
  int n_fail = 0;

  jk_async_sync #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .J(J), .K(K), .Q_asyn(Q_asyn), .Q_syn(Q_syn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic both(input string tag, input logic [3:0] exp);
    chk({tag, "_syn"}, Q_syn, exp);
    chk({tag, "_asyn"}, Q_asyn, exp);
  endtask

  initial begin
    reset = 1'b1; J = 4'hF; K = 4'h0;
    step();
    both("reset", 4'h0);
    reset = 1'b0;
    #1 chk("release_asyn", Q_asyn, 4'h0);
    step();
    both("first_set", 4'hF);
    J = 4'h0; K = 4'hF; step(); both("clear", 4'h0);
    J = 4'h0; K = 4'h0; step(); both("hold0_a", 4'h0);
    step(); both("hold0_b", 4'h0);
    J = 4'hF; K = 4'h0; step(); both("set", 4'hF);
    J = 4'h0; K = 4'h0; step(); both("hold1", 4'hF);
    J = 4'hF; K = 4'hF;
    step(); both("tgl1", 4'h0);
    step(); both("tgl2", 4'hF);
    step(); both("tgl3", 4'h0);
    J = 4'hF; K = 4'h0; step(); both("reset1", 4'hF);
    J = 4'h0; K = 4'h0; reset = 1'b1;
    #1;
    chk("mid_asyn", Q_asyn, 4'h0);
    chk("mid_syn", Q_syn, 4'hF);
    step(); both("mid_edge", 4'h0);
    reset = 1'b0;
    step(); both("mid_hold_a", 4'h0);
    step(); both("mid_hold_b", 4'h0);
    J = 4'hF; K = 4'h0; step(); both("preglitch", 4'hF);
    J = 4'h0; K = 4'h0; reset = 1'b1;
    #1;
    chk("glitch_asyn", Q_asyn, 4'h0);
    chk("glitch_syn", Q_syn, 4'hF);
    reset = 1'b0;
    #1 both("post_glitch", 4'hF);
    step(); both("glitch_edge", 4'hF);
    J = 4'b0011; K = 4'b1100; step(); both("w_init", 4'b0011);
    J = 4'b1010; K = 4'b0110; step(); both("w_mix", 4'b1001);
    J = 4'hF; K = 4'hF; reset = 1'b1; step(); both("reset_prio", 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
